wta_spike_ctrl: RTL and testbench

WTA_SPIKE_CTRL -- requirements
Module: wta_spike_ctrl

---
 rtl/wta_spike_ctrl_if.sv | 27 ++
 rtl/wta_spike_ctrl.sv | 152 +++++++++++++++
 tb/tb_wta_spike_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wta_spike_ctrl_if.sv
// Bus bundle between the winner-take-all spike controller and the neuron array.
// The neuron side drives the event and thresholded outputs; the controller answers with spikes and status.
interface wta_spike_ctrl_if #(
    parameter int p_width = 20
);
    logic               i_event;
    logic [p_width-1:0] i_neuron_out_1;
    logic [p_width-1:0] i_neuron_out_2;
    logic [p_width-1:0] i_neuron_out_3;
    logic [p_width-1:0] i_neuron_out_4;
    logic [4:1]         o_spike;
    logic [1:0]         o_winner;
    logic [p_width-1:0] o_win_value;
    logic               o_no_winner;
    logic               o_busy;
    logic [7:0]         o_drop_cnt;

    modport master (
        output i_event, i_neuron_out_1, i_neuron_out_2, i_neuron_out_3, i_neuron_out_4,
        input  o_spike, o_winner, o_win_value, o_no_winner, o_busy, o_drop_cnt
    );

    modport slave (
        input  i_event, i_neuron_out_1, i_neuron_out_2, i_neuron_out_3, i_neuron_out_4,
        output o_spike, o_winner, o_win_value, o_no_winner, o_busy, o_drop_cnt
    );
endinterface

// File: rtl/wta_spike_ctrl.sv
// Winner-take-all spike controller: settles, picks the largest nonzero neuron output, spikes it, then refracts.
// Define WTA_RR_TIE_EN to break ties round-robin instead of lowest index.
module wta_spike_ctrl #(
    parameter int p_width          = 20,
    parameter int p_refract_cycles = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    wta_spike_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_SPIKE,
        ST_REFRACT
    } state_t;

    localparam logic [7:0] lp_refract = 8'(p_refract_cycles);

    state_t             state_reg, state_next;
    logic [7:0]         refract_cnt_reg, refract_cnt_next;
    logic [4:1]         spike_reg, spike_next;
    logic [1:0]         winner_reg, winner_next;
    logic [p_width-1:0] win_value_reg, win_value_next;
    logic               no_winner_reg, no_winner_next;
    logic               busy_reg, busy_next;
    logic [7:0]         drop_cnt_reg, drop_cnt_next;

    logic [p_width-1:0] neuron_val [4];
    logic [1:0]         rot_idx [4];
    logic [1:0]         rr_ptr;
    logic [p_width-1:0] best_val;
    logic [1:0]         best_idx;
    logic               found;

    assign neuron_val[0] = bus.i_neuron_out_1;
    assign neuron_val[1] = bus.i_neuron_out_2;
    assign neuron_val[2] = bus.i_neuron_out_3;
    assign neuron_val[3] = bus.i_neuron_out_4;

`ifdef WTA_RR_TIE_EN
    logic [1:0] rr_ptr_reg;

    // Priority starts just after the last winner; untouched when nobody wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rr_ptr_reg <= 2'd0;
        else if (state_reg == ST_DECIDE && found)
            rr_ptr_reg <= best_idx + 2'd1;
    end
    assign rr_ptr = rr_ptr_reg;
`else
    assign rr_ptr = 2'd0;
`endif

    // Search order begins at rr_ptr and wraps 4 -> 1.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_idx[gi] = rr_ptr + 2'(gi);
        end
    endgenerate

    // Strict '>' keeps the earliest candidate in search order on a tie; zero never wins.
    always_comb begin
        best_val = '0;
        best_idx = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (neuron_val[rot_idx[k]] > best_val) begin
                best_val = neuron_val[rot_idx[k]];
                best_idx = rot_idx[k];
            end
        end
    end
    assign found = (best_val != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg       <= ST_IDLE;
            refract_cnt_reg <= 8'd0;
            spike_reg       <= 4'b0000;
            winner_reg      <= 2'd0;
            win_value_reg   <= '0;
            no_winner_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            drop_cnt_reg    <= 8'd0;
        end else begin
            state_reg       <= state_next;
            refract_cnt_reg <= refract_cnt_next;
            spike_reg       <= spike_next;
            winner_reg      <= winner_next;
            win_value_reg   <= win_value_next;
            no_winner_reg   <= no_winner_next;
            busy_reg        <= busy_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        refract_cnt_next = refract_cnt_reg;
        case (state_reg)
            ST_IDLE:   if (bus.i_event) state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_DECIDE;
            ST_DECIDE: state_next = found ? ST_SPIKE : ST_IDLE;
            ST_SPIKE: begin
                if (lp_refract == 8'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next       = ST_REFRACT;
                    refract_cnt_next = lp_refract - 8'd1;
                end
            end
            ST_REFRACT: begin
                if (refract_cnt_reg == 8'd0)
                    state_next = ST_IDLE;
                else
                    refract_cnt_next = refract_cnt_reg - 8'd1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output values are computed here and registered alongside the state.
    always_comb begin
        spike_next     = 4'b0000;
        no_winner_next = 1'b0;
        winner_next    = winner_reg;
        win_value_next = win_value_reg;
        busy_next      = (state_next != ST_IDLE);
        drop_cnt_next  = drop_cnt_reg;
        if (bus.i_event && state_reg != ST_IDLE && drop_cnt_reg != 8'hFF)
            drop_cnt_next = drop_cnt_reg + 8'd1;
        if (state_reg == ST_DECIDE) begin
            if (found) begin
                spike_next     = 4'b0001 << best_idx;
                winner_next    = best_idx;
                win_value_next = best_val;
            end else begin
                no_winner_next = 1'b1;
            end
        end
    end

    assign bus.o_spike     = spike_reg;
    assign bus.o_winner    = winner_reg;
    assign bus.o_win_value = win_value_reg;
    assign bus.o_no_winner = no_winner_reg;
    assign bus.o_busy      = busy_reg;
    assign bus.o_drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_wta_spike_ctrl.sv
// Testbench for wta_spike_ctrl: two instances (refractory 4 and 0) share stimulus; a timeline model
// predicts decisions into per-instance queues that a monitor drains whenever a spike or no-winner appears.
module tb_wta_spike_ctrl;
    localparam int W = 20;
    typedef logic [W-1:0] vec4_t [4];

    typedef struct {
        int         edge_n;
        logic [3:0] spike;
        logic       nw;
        logic [1:0] win;
        logic [W-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wta_spike_ctrl_if #(.p_width(W)) bus0 ();
    wta_spike_ctrl_if #(.p_width(W)) bus1 ();

    wta_spike_ctrl #(.p_width(W), .p_refract_cycles(4)) dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0));
    wta_spike_ctrl #(.p_width(W), .p_refract_cycles(0)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));

    logic [3:0]   spk  [2];
    logic         nw   [2];
    logic [1:0]   win  [2];
    logic [W-1:0] val  [2];
    logic         busy [2];
    logic [7:0]   drop [2];
    assign spk[0] = bus0.o_spike;     assign spk[1] = bus1.o_spike;
    assign nw[0]  = bus0.o_no_winner; assign nw[1]  = bus1.o_no_winner;
    assign win[0] = bus0.o_winner;    assign win[1] = bus1.o_winner;
    assign val[0] = bus0.o_win_value; assign val[1] = bus1.o_win_value;
    assign busy[0] = bus0.o_busy;     assign busy[1] = bus1.o_busy;
    assign drop[0] = bus0.o_drop_cnt; assign drop[1] = bus1.o_drop_cnt;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: per instance, the edge at which the controller accepts again,
    // the pending decision edge, and the last announced winner.
    int           refr [2] = '{4, 0};
    int           free_at [2];
    int           last_acc [2];
    int           pend [2];
    int           drop_m [2];
    int           rr [2];
    logic [1:0]   lwin [2];
    logic [W-1:0] lval [2];
    exp_t         ring [2][64];
    int           wr [2];
    int           rd [2];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h, expected %0h", name, inst, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            free_at[i]  = 0;
            last_acc[i] = -1000;
            pend[i]     = -1;
            drop_m[i]   = 0;
            rr[i]       = 0;
            lwin[i]     = 2'd0;
            lval[i]     = '0;
            rd[i]       = wr[i];
        end
    endtask

    // Largest nonzero value; among equal maxima, the first one met scanning from ptr with wrap.
    function automatic int pick(input vec4_t v, input int ptr);
        logic [W-1:0] mx;
        int w;
        mx = '0;
        w  = -1;
        for (int k = 0; k < 4; k++) if (v[k] > mx) mx = v[k];
        if (mx != '0)
            for (int k = 0; k < 4; k++)
                if (w < 0 && v[(ptr + k) % 4] == mx) w = (ptr + k) % 4;
        return w;
    endfunction

    task automatic push(input int i, input exp_t e);
        ring[i][wr[i] % 64] = e;
        wr[i]++;
    endtask

    // One cycle of stimulus: values and event are sampled at the next rising edge (edge n).
    task automatic drive(input logic ev, input vec4_t v);
        int n;
        int w;
        int ptr;
        exp_t e;
        @(negedge clk);
        n = edge_cnt + 1;
        bus0.i_event = ev; bus1.i_event = ev;
        bus0.i_neuron_out_1 = v[0]; bus1.i_neuron_out_1 = v[0];
        bus0.i_neuron_out_2 = v[1]; bus1.i_neuron_out_2 = v[1];
        bus0.i_neuron_out_3 = v[2]; bus1.i_neuron_out_3 = v[2];
        bus0.i_neuron_out_4 = v[3]; bus1.i_neuron_out_4 = v[3];
        for (int i = 0; i < 2; i++) begin
            if (pend[i] == n) begin
`ifdef WTA_RR_TIE_EN
                ptr = rr[i];
`else
                ptr = 0;
`endif
                w = pick(v, ptr);
                pend[i] = -1;
                if (w < 0) begin
                    e = '{n, 4'b0000, 1'b1, lwin[i], lval[i]};
                    free_at[i] = n + 1;
                end else begin
                    lwin[i] = 2'(w);
                    lval[i] = v[w];
                    rr[i] = (w + 1) % 4;
                    e = '{n, 4'(1 << w), 1'b0, lwin[i], lval[i]};
                    free_at[i] = n + refr[i] + 2;
                end
                push(i, e);
            end
            if (ev) begin
                if (n >= free_at[i]) begin
                    last_acc[i] = n;
                    free_at[i]  = n + 3;
                    pend[i]     = n + 2;
                end else if (drop_m[i] < 255) begin
                    drop_m[i]++;
                end
            end
        end
    endtask

    function automatic logic [W-1:0] rand_val();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return W'($urandom_range(1, 5) * 100);
            2: return {W{1'b1}};
            3: return W'(20'h80000);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_spike"}, i, 32'(spk[i]), 0);
            chk({tag, "_winner"}, i, 32'(win[i]), 0);
            chk({tag, "_value"}, i, 32'(val[i]), 0);
            chk({tag, "_no_winner"}, i, 32'(nw[i]), 0);
            chk({tag, "_busy"}, i, 32'(busy[i]), 0);
            chk({tag, "_drop"}, i, 32'(drop[i]), 0);
        end
    endtask

    // Monitor: checks status every cycle and drains the expectation queue on each decision output.
    always @(posedge clk) begin
        int k;
        exp_t e;
        #1;
        if (rst_n) begin
            k = edge_cnt;
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 32'(busy[i]), 32'(k >= last_acc[i] && k < free_at[i] - 1));
                chk("drop_cnt", i, 32'(drop[i]), 32'(drop_m[i]));
                chk("winner_held", i, 32'(win[i]), 32'(lwin[i]));
                chk("value_held", i, 32'(val[i]), 32'(lval[i]));
                if (spk[i] != 4'b0000 || nw[i]) begin
                    if (rd[i] == wr[i]) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_out[dut%0d] edge=%0d: spike=%b no_winner=%0b, expected none", i, k, spk[i], nw[i]);
                    end else begin
                        e = ring[i][rd[i] % 64];
                        rd[i]++;
                        chk("out_edge", i, 32'(k), 32'(e.edge_n));
                        chk("spike", i, 32'(spk[i]), 32'(e.spike));
                        chk("no_winner", i, 32'(nw[i]), 32'(e.nw));
                        chk("winner", i, 32'(win[i]), 32'(e.win));
                        chk("win_value", i, 32'(val[i]), 32'(e.val));
                    end
                end else if (rd[i] != wr[i] && ring[i][rd[i] % 64].edge_n <= k) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_out[dut%0d] edge=%0d: got nothing, expected spike=%b no_winner=%0b", i, k,
                             ring[i][rd[i] % 64].spike, ring[i][rd[i] % 64].nw);
                    rd[i]++;
                end
            end
        end
    end

    initial begin
        vec4_t v;
        wr[0] = 0; wr[1] = 0;
        model_reset();
        v = '{0, 0, 0, 0};
        bus0.i_event = 1'b0; bus1.i_event = 1'b0;
        bus0.i_neuron_out_1 = '0; bus0.i_neuron_out_2 = '0; bus0.i_neuron_out_3 = '0; bus0.i_neuron_out_4 = '0;
        bus1.i_neuron_out_1 = '0; bus1.i_neuron_out_2 = '0; bus1.i_neuron_out_3 = '0; bus1.i_neuron_out_4 = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single clear winner, then all-zero decision.
        v = '{0, 300, 150, 0};
        drive(1'b1, v);
        repeat (10) drive(1'b0, v);
        v = '{0, 0, 0, 0};
        drive(1'b1, v);
        repeat (6) drive(1'b0, v);

        // Repeated tie.
        v = '{500, 0, 500, 0};
        repeat (3) begin
            drive(1'b1, v);
            repeat (9) drive(1'b0, v);
        end

        // Second event four cycles later: accepted only with zero refractory.
        v = '{0, 0, 0, 9};
        drive(1'b1, v);
        repeat (3) drive(1'b0, v);
        drive(1'b1, v);
        repeat (10) drive(1'b0, v);

        // Event every cycle: spikes spaced by the refractory window, drop counter saturates.
        v = '{7, 7, 3, 7};
        repeat (300) drive(1'b1, v);
        repeat (10) drive(1'b0, v);

        // Asynchronous reset while the first instance is refracting.
        v = '{10, 20, 30, 40};
        drive(1'b1, v);
        repeat (4) drive(1'b0, v);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        v = '{5, 1, 5, 2};
        drive(1'b1, v);
        repeat (8) drive(1'b0, v);

        // Randomized traffic.
        repeat (800) begin
            for (int j = 0; j < 4; j++) v[j] = rand_val();
            drive($urandom_range(0, 9) < 4, v);
        end
        v = '{0, 0, 0, 0};
        repeat (12) drive(1'b0, v);

        for (int i = 0; i < 2; i++) chk("queue_drained", i, 32'(wr[i] - rd[i]), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
